// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped tagged table of saturating counters
// and targets. Combinational lookup for IF, training from the ID-stage branch
// resolution, combinational mispredict/redirect, and saturating statistics.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IF_PC,
    input  logic [5:0]  IF_op,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ID_update,
    input  logic [31:0] ID_PC,
    input  logic        ID_pred_taken,
    input  logic [31:0] ID_pred_target,
    input  logic        ID_taken,
    input  logic [31:0] ID_target,
    output logic        mispredict,
    output logic [31:0] redirect_PC,
    output logic [31:0] branch_count,
    output logic [31:0] miss_count
);

    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_LO  = INDEX_W + 2;
    localparam int TAG_HI  = INDEX_W + TAG_W + 1;

    // Counter encodings: all-ones ceiling, weakly not-taken (0 then ones)
    // after reset, weakly taken (1 then zeros) on allocation.
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_MAX >> 1;
    localparam logic [CNT_W-1:0] CNT_ALLOC = ~CNT_RST;

    // Predictor table
    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    // Statistics
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] miss_count_q,   miss_count_d;

    // Lookup side (IF)
    logic [INDEX_W-1:0] if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic               if_hit;
    logic               is_branch;

    // Training side (ID)
    logic [INDEX_W-1:0] id_idx;
    logic [TAG_W-1:0]   id_tag;
    logic               id_hit;
    logic               upd_we;
    logic [31:0]        upd_target_d;
    logic [CNT_W-1:0]   upd_cnt_d;

    // Upper/lower PC bits that never reach the index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC, ID_PC};

    assign if_idx = IF_PC[INDEX_W+1:2];
    assign if_tag = IF_PC[TAG_HI:TAG_LO];
    assign id_idx = ID_PC[INDEX_W+1:2];
    assign id_tag = ID_PC[TAG_HI:TAG_LO];

    assign is_branch = IF_op inside {6'b000100, 6'b000101, 6'b000110,
                                     6'b000111, 6'b000001};

    // Lookup reads the registered table only, so a same-cycle update is not
    // visible until the following cycle.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = is_branch && if_hit && cnt_q[if_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : (IF_PC + 32'd4);

    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    // Wrong direction, or right "taken" direction but wrong target.
    assign mispredict  = ID_update &&
                         ((ID_pred_taken != ID_taken) ||
                          (ID_taken && (ID_pred_target != ID_target)));
    assign redirect_PC = ID_taken ? ID_target : (ID_PC + 32'd4);

    // Next contents of the ID-indexed entry and whether to write it
    always_comb begin
        upd_we       = 1'b0;
        upd_target_d = target_q[id_idx];
        upd_cnt_d    = cnt_q[id_idx];
        if (ID_update) begin
            if (id_hit) begin
                upd_we = 1'b1;
                if (ID_taken) begin
                    upd_target_d = ID_target;
                    if (cnt_q[id_idx] != CNT_MAX) begin
                        upd_cnt_d = cnt_q[id_idx] + CNT_W'(1);
                    end
                end else if (cnt_q[id_idx] != '0) begin
                    upd_cnt_d = cnt_q[id_idx] - CNT_W'(1);
                end
            end else if (ID_taken) begin
                // Allocate, evicting whatever aliased entry was there.
                upd_we       = 1'b1;
                upd_target_d = ID_target;
                upd_cnt_d    = CNT_ALLOC;
            end
        end
    end

    // Table state: cleared by reset, one entry written per training update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_RST;
            end
        end else if (upd_we) begin
            valid_q[id_idx]  <= 1'b1;
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= upd_target_d;
            cnt_q[id_idx]    <= upd_cnt_d;
        end
    end

    // Saturating next values for the statistics counters
    always_comb begin
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;
        if (ID_update && (branch_count_q != 32'hFFFF_FFFF)) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign branch_count = branch_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vectors with literal expectations,
// plus a behavioural table model compared against every output each cycle.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int IW      = $clog2(ENTRIES);
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CHALF   = 1 << (CNT_W - 1);

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_REGI = 6'b000001;
    localparam logic [5:0] OP_ALU  = 6'b000000;

    logic        clock;
    logic        reset;
    logic [31:0] IF_PC;
    logic [5:0]  IF_op;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ID_update;
    logic [31:0] ID_PC;
    logic        ID_pred_taken;
    logic [31:0] ID_pred_target;
    logic        ID_taken;
    logic [31:0] ID_target;
    logic        mispredict;
    logic [31:0] redirect_PC;
    logic [31:0] branch_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    branch_predictor #(
        .ENTRIES(ENTRIES),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .IF_PC         (IF_PC),
        .IF_op         (IF_op),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ID_update     (ID_update),
        .ID_PC         (ID_PC),
        .ID_pred_taken (ID_pred_taken),
        .ID_pred_target(ID_pred_target),
        .ID_taken      (ID_taken),
        .ID_target     (ID_target),
        .mispredict    (mispredict),
        .redirect_PC   (redirect_PC),
        .branch_count  (branch_count),
        .miss_count    (miss_count)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    longint      m_bc;
    longint      m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IW)) % (1 << TAG_W));
    endfunction

    function automatic bit is_br(input logic [5:0] op);
        return (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7) || (op == 6'd1);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc, input logic [5:0] op);
        return is_br(op) && m_hit(pc) && (m_cnt[idx_of(pc)] >= CHALF);
    endfunction

    function automatic bit m_miss();
        return ID_update && ((ID_pred_taken != ID_taken) ||
                             (ID_taken && (ID_pred_target != ID_target)));
    endfunction

    // Model state advances on the same edges as the design.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= 0;
                m_tgt[i]   <= 32'h0;
                m_cnt[i]   <= CHALF - 1;
            end
            m_bc <= 0;
            m_mc <= 0;
        end else if (ID_update) begin
            m_bc <= (m_bc < 64'hFFFF_FFFF) ? m_bc + 1 : m_bc;
            if (m_miss()) m_mc <= (m_mc < 64'hFFFF_FFFF) ? m_mc + 1 : m_mc;
            if (m_hit(ID_PC)) begin
                if (ID_taken) begin
                    m_cnt[idx_of(ID_PC)] <= (m_cnt[idx_of(ID_PC)] < CMAX) ? m_cnt[idx_of(ID_PC)] + 1 : CMAX;
                    m_tgt[idx_of(ID_PC)] <= ID_target;
                end else begin
                    m_cnt[idx_of(ID_PC)] <= (m_cnt[idx_of(ID_PC)] > 0) ? m_cnt[idx_of(ID_PC)] - 1 : 0;
                end
            end else if (ID_taken) begin
                m_valid[idx_of(ID_PC)] <= 1'b1;
                m_tag[idx_of(ID_PC)]   <= tag_of(ID_PC);
                m_tgt[idx_of(ID_PC)]   <= ID_target;
                m_cnt[idx_of(ID_PC)]   <= CHALF;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cmp_pred_taken", {31'b0, pred_taken}, {31'b0, m_pred(IF_PC, IF_op)});
            chk("cmp_pred_target", pred_target,
                m_pred(IF_PC, IF_op) ? m_tgt[idx_of(IF_PC)] : IF_PC + 32'd4);
            chk("cmp_mispredict", {31'b0, mispredict}, {31'b0, m_miss()});
            chk("cmp_redirect_PC", redirect_PC, ID_taken ? ID_target : ID_PC + 32'd4);
            chk("cmp_branch_count", branch_count, m_bc[31:0]);
            chk("cmp_miss_count", miss_count, m_mc[31:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_if(input logic [31:0] pc, input logic [5:0] op);
        IF_PC = pc;
        IF_op = op;
    endtask

    task automatic drive_id(input logic upd, input logic [31:0] pc, input logic ptk,
                            input logic [31:0] ptgt, input logic tk, input logic [31:0] tgt);
        ID_update      = upd;
        ID_PC          = pc;
        ID_pred_taken  = ptk;
        ID_pred_target = ptgt;
        ID_taken       = tk;
        ID_target      = tgt;
    endtask

    task automatic id_idle();
        drive_id(1'b0, 32'h0040_0000, 1'b0, 32'h0040_0004, 1'b0, 32'h0);
    endtask

    // Move from "negedge checks done" to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        drive_if(32'h0040_0010, OP_BEQ);
        id_idle();
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Post-reset lookup
        @(negedge clock);
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h0040_0014);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        next_cycle();

        // Cold taken branch; lookup in the same cycle still sees the old table
        drive_id(1'b1, 32'h0040_0010, 1'b0, 32'h0040_0014, 1'b1, 32'h0040_0040);
        @(negedge clock);
        chk("cold_mispredict", {31'b0, mispredict}, 32'd1);
        chk("cold_redirect", redirect_PC, 32'h0040_0040);
        chk("cold_no_bypass", {31'b0, pred_taken}, 32'd0);
        next_cycle();

        id_idle();
        @(negedge clock);
        chk("trained_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("trained_pred_target", pred_target, 32'h0040_0040);
        next_cycle();

        // Three correct taken updates saturate the counter
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
            @(negedge clock);
            chk("taken_ok_mispredict", {31'b0, mispredict}, 32'd0);
            next_cycle();
        end

        // First not-taken: still predicted taken afterwards
        drive_id(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0040);
        @(negedge clock);
        chk("nt1_pred_before", {31'b0, pred_taken}, 32'd1);
        chk("nt1_mispredict", {31'b0, mispredict}, 32'd1);
        chk("nt1_redirect", redirect_PC, 32'h0040_0014);
        next_cycle();

        // Second not-taken: prediction drops only after this one
        @(negedge clock);
        chk("nt2_pred_before", {31'b0, pred_taken}, 32'd1);
        next_cycle();

        id_idle();
        @(negedge clock);
        chk("nt2_pred_after", {31'b0, pred_taken}, 32'd0);
        chk("nt2_target_after", pred_target, 32'h0040_0014);
        next_cycle();

        // Aliasing: 0x00400110 shares the index and evicts 0x00400010
        drive_id(1'b1, 32'h0040_0110, 1'b0, 32'h0040_0114, 1'b1, 32'h0040_0500);
        @(negedge clock);
        next_cycle();

        id_idle();
        @(negedge clock);
        chk("alias_evicted", {31'b0, pred_taken}, 32'd0);
        next_cycle();

        // Target change on a hit with the right direction
        drive_if(32'h0040_0110, OP_BEQ);
        drive_id(1'b1, 32'h0040_0110, 1'b1, 32'h0040_0500, 1'b1, 32'h0040_0600);
        @(negedge clock);
        chk("alias_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("alias_pred_target", pred_target, 32'h0040_0500);
        chk("tgtchg_mispredict", {31'b0, mispredict}, 32'd1);
        chk("tgtchg_redirect", redirect_PC, 32'h0040_0600);
        next_cycle();

        id_idle();
        drive_if(32'h0040_0110, OP_REGI);
        @(negedge clock);
        chk("tgtchg_new_target", pred_target, 32'h0040_0600);
        chk("regimm_pred_taken", {31'b0, pred_taken}, 32'd1);
        next_cycle();

        // Non-branch opcode never predicts taken
        drive_if(32'h0040_0110, OP_ALU);
        @(negedge clock);
        chk("nonbr_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("nonbr_pred_target", pred_target, 32'h0040_0114);
        chk("seq_branch_count", branch_count, 32'd8);
        chk("seq_miss_count", miss_count, 32'd5);
        next_cycle();

        // Reset mid-cycle clears statistics at once and discards the held update
        drive_if(32'h0040_0110, OP_BEQ);
        drive_id(1'b1, 32'h0040_0300, 1'b0, 32'h0040_0304, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_branch_count", branch_count, 32'd0);
        chk("async_rst_miss_count", miss_count, 32'd0);
        chk("async_rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        @(negedge clock);
        chk("rst_held_branch_count", branch_count, 32'd0);
        next_cycle();
        chk("first_after_rst_count", branch_count, 32'd1);
        id_idle();
        @(negedge clock);
        next_cycle();

        // Statistics: 10 updates, mispredicts at updates 2, 5 and 8
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_id(1'b1, 32'h0040_0200 + 32'(i * 4),
                     ((i == 2) || (i == 5) || (i == 8)) ? ~i[0] : i[0],
                     32'h0040_0800, i[0], 32'h0040_0800);
            @(negedge clock);
            next_cycle();
        end
        id_idle();
        @(negedge clock);
        chk("stats_branch_count", branch_count, 32'd10);
        chk("stats_miss_count", miss_count, 32'd3);
        next_cycle();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
